// File: rtl/elem_seq_pkg.sv
// Shared types and widths for the per-element pulse sequencer.
// The command word is stored whole in the queue; the sideband word travels down the delay pipe.
package elem_seq_pkg;

    localparam int ENV_ADDR_WIDTH   = 12;
    localparam int AMP_WIDTH        = 16;
    localparam int FREQ_WIDTH       = 9;
    localparam int PHASE_WIDTH      = 17;
    localparam int MODE_WIDTH       = 2;
    localparam int QUEUE_DEPTH      = 2;
    localparam int ENV_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [ENV_ADDR_WIDTH-1:0] envstart;
        logic [ENV_ADDR_WIDTH-1:0] envlength;
        logic [AMP_WIDTH-1:0]      ampx;
        logic [FREQ_WIDTH-1:0]     freqaddr;
        logic [PHASE_WIDTH-1:0]    pini;
        logic [MODE_WIDTH-1:0]     mode;
    } elem_cmd_t;

    typedef struct packed {
        logic                   valid;
        logic [AMP_WIDTH-1:0]   amp;
        logic [FREQ_WIDTH-1:0]  freqaddr;
        logic [PHASE_WIDTH-1:0] phase;
        logic                   first;
        logic                   last;
    } side_t;

    // Only mode[0] carries meaning; the upper mode bits are reserved.
    function automatic logic is_cw(input logic [MODE_WIDTH-1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/elem_cmd_fifo.sv
// Small first-word-fall-through command queue; head is valid whenever empty is low.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module elem_cmd_fifo
    import elem_seq_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  elem_cmd_t push_data,
    input  logic      pop,
    output elem_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    elem_cmd_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/elem_pulse_seq.sv
// Per-element pulse sequencer: queues core commands, walks envelope addresses, and
// delays the amp/freq/phase sideband so it lines up with the returned envelope data.
module elem_pulse_seq
    import elem_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmdstb,
    input  logic [ENV_ADDR_WIDTH-1:0] envstart,
    input  logic [ENV_ADDR_WIDTH-1:0] envlength,
    input  logic [AMP_WIDTH-1:0]      ampx,
    input  logic [FREQ_WIDTH-1:0]     freqaddr,
    input  logic [PHASE_WIDTH-1:0]    pini,
    input  logic [MODE_WIDTH-1:0]     mode,
    output logic                      env_rden,
    output logic [ENV_ADDR_WIDTH-1:0] env_addr,
    output logic                      out_valid,
    output logic [AMP_WIDTH-1:0]      out_amp,
    output logic [FREQ_WIDTH-1:0]     out_freqaddr,
    output logic [PHASE_WIDTH-1:0]    out_phase,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overflow
);

    elem_cmd_t push_cmd;
    elem_cmd_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    logic      load;
    logic      mode_rsvd_unused;

    seq_state_t                state_reg, state_next;
    logic [ENV_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ENV_ADDR_WIDTH-1:0] rem_reg, rem_next;
    logic                      first_reg, first_next;
    logic [AMP_WIDTH-1:0]      amp_reg, amp_next;
    logic [FREQ_WIDTH-1:0]     freq_reg, freq_next;
    logic [PHASE_WIDTH-1:0]    phase_reg, phase_next;
    logic                      cw_reg, cw_next;
    logic                      overflow_reg;

    side_t                       side_in;
    side_t                       side_out;
    logic [ENV_READ_LATENCY-1:0] stage_valid;

    always_comb begin
        push_cmd           = '0;
        push_cmd.envstart  = envstart;
        push_cmd.envlength = envlength;
        push_cmd.ampx      = ampx;
        push_cmd.freqaddr  = freqaddr;
        push_cmd.pini      = pini;
        push_cmd.mode      = mode;
    end

    // A full queue still takes the strobe if the sequencer drains an entry this cycle.
    assign fifo_push = cmdstb && (!fifo_full || fifo_pop);

    elem_cmd_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(push_cmd),
        .pop      (fifo_pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign mode_rsvd_unused = |head.mode[MODE_WIDTH-1:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            rem_reg      <= '0;
            first_reg    <= 1'b0;
            amp_reg      <= '0;
            freq_reg     <= '0;
            phase_reg    <= '0;
            cw_reg       <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rem_reg   <= rem_next;
            first_reg <= first_next;
            amp_reg   <= amp_next;
            freq_reg  <= freq_next;
            phase_reg <= phase_next;
            cw_reg    <= cw_next;
            if (cmdstb && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // rem_reg counts the words still to issue after the current one.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rem_next   = rem_reg;
        first_next = first_reg;
        amp_next   = amp_reg;
        freq_next  = freq_reg;
        phase_next = phase_reg;
        cw_next    = cw_reg;
        fifo_pop   = 1'b0;
        load       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.envlength != '0) begin
                        load       = 1'b1;
                        state_next = PLAY;
                    end
                end
            end
            PLAY: begin
                first_next = 1'b0;
                if (rem_reg != '0) begin
                    addr_next = addr_reg + 1'b1;
                    rem_next  = rem_reg - 1'b1;
                end else if (cw_reg) begin
                    state_next = HOLD;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.envlength != '0) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // A zero-length command is how the core ends a CW hold without a new pulse.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.envlength != '0) begin
                        load       = 1'b1;
                        state_next = PLAY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            addr_next  = head.envstart;
            rem_next   = head.envlength - 1'b1;
            first_next = 1'b1;
            amp_next   = head.ampx;
            freq_next  = head.freqaddr;
            phase_next = head.pini;
            cw_next    = is_cw(head.mode);
        end
    end

    always_comb begin
        env_rden = (state_reg != IDLE);
        env_addr = '0;
        side_in  = '0;
        if (env_rden) begin
            env_addr         = addr_reg;
            side_in.valid    = 1'b1;
            side_in.amp      = amp_reg;
            side_in.freqaddr = freq_reg;
            side_in.phase    = phase_reg;
            side_in.first    = (state_reg == PLAY) && first_reg;
            side_in.last     = (state_reg == PLAY) && (rem_reg == '0) && !cw_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENV_READ_LATENCY; gi++) begin : g_stage
            side_t stage_reg;
            side_t stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = side_in;
            end else begin : g_tail
                assign stage_in = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
            assign stage_valid[gi] = stage_reg.valid;
        end
    endgenerate

    assign side_out     = g_stage[ENV_READ_LATENCY-1].stage_reg;
    assign out_valid    = side_out.valid;
    assign out_amp      = side_out.amp;
    assign out_freqaddr = side_out.freqaddr;
    assign out_phase    = side_out.phase;
    assign out_first    = side_out.first;
    assign out_last     = side_out.last;

    // Built purely from flops, so busy changes only on clock edges.
    assign busy     = !fifo_empty || (state_reg != IDLE) || (|stage_valid);
    assign overflow = overflow_reg;

endmodule
